ssd_frame_reader: RTL
=====================

SSD_FRAME_READER -- requirements
Module: ssd_frame_reader

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive identical cycles required before a digit is accepted; legal range 2..15.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port SEG, input, [0:6]: segment lines a..g, active-low (0 = segment lit).
REQ-005 SHALL have port DIG, input, [3:0]: digit strobes, active-low; DIG[i]=0 selects digit i.
REQ-006 SHALL have port CODE, output, [15:0]: decoded frame; digit i occupies CODE[4i+3:4i].
REQ-007 SHALL have port BLANK, output, [3:0]: BLANK[i]=1 means digit i was all segments off.
REQ-008 SHALL have port ERR, output, [3:0]: ERR[i]=1 means the digit i pattern matched no glyph.
REQ-009 SHALL have port VALID, output, 1 bit: a frame is held on CODE/BLANK/ERR.
REQ-010 SHALL have port ACK, input, 1 bit: consumer accepts the held frame.
REQ-011 SHALL have port OVR, output, 1 bit: sticky flag, set when a frame is dropped.

Function
REQ-012 SHALL treat a cycle as qualified only when DIG has exactly one bit low.
REQ-013 SHALL count dwell cycles where DIG and SEG equal their previous-cycle values and the cycle is qualified; any change or unqualified cycle resets the count to 0.
REQ-014 SHALL capture the decoded digit into slot i when the dwell count reaches STABLE_CYC-1, and set mask bit i.
REQ-015 SHALL capture at most once per dwell; re-arm only after DIG or SEG changes.
REQ-016 SHALL overwrite slot i if it is captured again before the frame completes.
REQ-017 SHALL decode the standard 16 hex glyphs 0..F (b and d lower-case, others upper-case) to codes 0x0..0xF.
REQ-018 SHALL decode SEG=1111111 as code 0 with BLANK set.
REQ-019 SHALL decode any other pattern as code 0 with ERR set.
REQ-020 SHALL use a frame FSM with two states: EMPTY (VALID=0) and HOLD (VALID=1).
REQ-021 SHALL register the frame on the cycle after the mask reaches 4'b1111: mask clears, and in EMPTY the slots load into CODE/BLANK/ERR, VALID rises, and the FSM enters HOLD.
REQ-022 SHALL, in HOLD with ACK=1 and no frame completing, return to EMPTY with VALID=0 on the next cycle.
REQ-023 SHALL, in HOLD when a frame completes with ACK=0, drop the new frame, keep the held outputs unchanged, and set OVR.
REQ-024 SHALL, in HOLD when a frame completes with ACK=1 in the same cycle, load the new frame and remain in HOLD; OVR is unchanged.
REQ-025 SHALL ignore ACK while in EMPTY.
REQ-026 SHALL continue collecting digits in both states.
REQ-027 SHALL have a latency of STABLE_CYC+1 cycles from the start of the final digit's dwell to VALID rising.
REQ-028 SHALL clear OVR only by Reset.

Reset
REQ-029 SHALL, on Reset=1 at a clock edge: CODE=0, BLANK=0, ERR=0, VALID=0, OVR=0, mask=0, dwell count=0, slots=0, FSM=EMPTY.
REQ-030 SHALL discard a partially collected frame or a held frame on Reset mid-operation; no VALID may appear until four fresh captures occur after Reset deasserts.

Structure
REQ-031 SHALL place the 16 active-low glyph constants, the blank constant, and the FSM state typedef in shared package ssd_pkg.
REQ-032 SHALL implement glyph decoding in combinational sub-module seg7_to_hex (SEG in; code, blank and err out), instantiated once on the live SEG input.
REQ-033 SHALL be sized for roughly 150-250 lines of RTL, excluding the package.

Verification
REQ-034 Basic frame (STABLE_CYC=4): digits 0..3 each held 6 cycles with glyphs 1,2,3,A (1=1001111, 2=0010010, 3=0000110, A=0001000) -> CODE=0xA321, BLANK=0, ERR=0, VALID=1 five cycles after digit 3 is first driven.
REQ-035 Unstable input: digit 2 SEG toggles every 2 cycles for 20 cycles -> no capture, mask bit 2 stays 0, VALID stays 0.
REQ-036 Illegal strobe: DIG=0011 held 10 cycles -> no capture; then DIG=1111 -> no capture.
REQ-037 Blank and error glyphs: digit 0 = 1111111, digit 1 = 1010101, digits 2,3 = glyph 0 (0000001) -> CODE=0x0000, BLANK=0001, ERR=0010.
REQ-038 Overrun: ACK=0 while a second frame 0xFFFF completes -> CODE stays at the first frame, OVR=1; then ACK=1 for one cycle -> VALID=0, OVR remains 1.
REQ-039 Reset mid-collection: Reset pulsed after 3 digits are captured -> all outputs 0; the 4th digit alone does not raise VALID.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared glyph constants (active-low, bit order a..g) and frame FSM states
// for the seven-segment frame reader.
package ssd_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } frame_state_e;

endpackage

// File: rtl/ssd_frame_reader_if.sv
// Bundle of the display-side inputs and frame-side outputs of the reader.
interface ssd_frame_reader_if;
    import ssd_pkg::*;

    seg_t        SEG;
    logic [3:0]  DIG;
    logic        ACK;
    logic [15:0] CODE;
    logic [3:0]  BLANK;
    logic [3:0]  ERR;
    logic        VALID;
    logic        OVR;

    modport master (output SEG, DIG, ACK, input CODE, BLANK, ERR, VALID, OVR);
    modport slave  (input SEG, DIG, ACK, output CODE, BLANK, ERR, VALID, OVR);
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational glyph decoder: active-low a..g pattern to hex code,
// flagging the all-off pattern as blank and anything unknown as error.
module seg7_to_hex
    import ssd_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] code,
    output logic       blank,
    output logic       err
);

    always_comb begin
        code  = 4'h0;
        blank = 1'b0;
        err   = 1'b0;
        case (seg)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_A:     code = 4'hA;
            SEG_B:     code = 4'hB;
            SEG_C:     code = 4'hC;
            SEG_D:     code = 4'hD;
            SEG_E:     code = 4'hE;
            SEG_F:     code = 4'hF;
            SEG_BLANK: blank = 1'b1;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_frame_reader.sv
// Samples a multiplexed 4-digit seven-segment display, debounces each digit,
// and presents complete frames with a VALID/ACK hold and sticky overrun flag.
module ssd_frame_reader
    import ssd_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  seg_t        SEG,
    input  logic [3:0]  DIG,
    output logic [15:0] CODE,
    output logic [3:0]  BLANK,
    output logic [3:0]  ERR,
    output logic        VALID,
    input  logic        ACK,
    output logic        OVR
);

    // Capture fires on the cycle whose dwell count advances to STABLE_CYC-1.
    localparam logic [3:0] CAP_AT  = 4'(STABLE_CYC - 2);
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC - 1);

    seg_t       prev_seg;
    logic [3:0] prev_dig;
    logic [3:0] cnt;
    logic [3:0] mask, mask_n;
    logic [NUM_DIGITS-1:0][3:0] slot_code;
    logic [NUM_DIGITS-1:0]      slot_blank;
    logic [NUM_DIGITS-1:0]      slot_err;

    logic [3:0] dec_code;
    logic       dec_blank, dec_err;
    logic       qualified, dwell, cap, frame_done;
    logic [1:0] idx;

    frame_state_e state, state_n;
    logic         load, set_ovr;

    seg7_to_hex u_dec (
        .seg   (SEG),
        .code  (dec_code),
        .blank (dec_blank),
        .err   (dec_err)
    );

    assign qualified  = $onehot(~DIG);
    assign dwell      = qualified && (SEG == prev_seg) && (DIG == prev_dig);
    assign cap        = dwell && (cnt == CAP_AT);
    assign frame_done = (mask == 4'b1111);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!DIG[i]) idx = 2'(i);
    end

    // A capture in the same cycle the frame is taken starts the next mask.
    always_comb begin
        mask_n = frame_done ? 4'b0000 : mask;
        if (cap) mask_n[idx] = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_seg   <= SEG_BLANK;
            prev_dig   <= 4'b1111;
            cnt        <= 4'd0;
            mask       <= 4'b0000;
            slot_code  <= '0;
            slot_blank <= '0;
            slot_err   <= '0;
        end else begin
            prev_seg <= SEG;
            prev_dig <= DIG;
            // Saturating at CNT_MAX keeps a long dwell from capturing twice.
            if (!dwell)              cnt <= 4'd0;
            else if (cnt != CNT_MAX) cnt <= cnt + 4'd1;
            mask <= mask_n;
            if (cap) begin
                slot_code[idx]  <= dec_code;
                slot_blank[idx] <= dec_blank;
                slot_err[idx]   <= dec_err;
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        set_ovr = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (frame_done) begin
                    load    = 1'b1;
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (frame_done) begin
                    if (ACK) load    = 1'b1;
                    else     set_ovr = 1'b1;
                end else if (ACK) begin
                    state_n = ST_EMPTY;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_EMPTY;
            CODE  <= 16'h0000;
            BLANK <= 4'b0000;
            ERR   <= 4'b0000;
            OVR   <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                CODE  <= slot_code;
                BLANK <= slot_blank;
                ERR   <= slot_err;
            end
            if (set_ovr) OVR <= 1'b1;
        end
    end

    assign VALID = (state == ST_HOLD);

endmodule
